// File: rtl/ysyx_23060184_mem_arbiter.sv
// Shares one AXI4-Lite slave port between NUM_MASTERS requesters (0 = IFU, 1 = LSU).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the highest index wins.
module ysyx_23060184_mem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_MASTERS-1:0]                req,
   output logic [NUM_MASTERS-1:0]                grant,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_araddr,
   input  logic [NUM_MASTERS-1:0]                m_arvalid,
   output logic [NUM_MASTERS-1:0]                m_arready,
   output logic [DATA_WIDTH-1:0]                 m_rdata,
   output logic [1:0]                            m_rresp,
   output logic [NUM_MASTERS-1:0]                m_rvalid,
   input  logic [NUM_MASTERS-1:0]                m_rready,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_awaddr,
   input  logic [NUM_MASTERS-1:0]                m_awvalid,
   output logic [NUM_MASTERS-1:0]                m_awready,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_wdata,
   input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_wstrb,
   input  logic [NUM_MASTERS-1:0]                m_wvalid,
   output logic [NUM_MASTERS-1:0]                m_wready,
   output logic [1:0]                            m_bresp,
   output logic [NUM_MASTERS-1:0]                m_bvalid,
   input  logic [NUM_MASTERS-1:0]                m_bready,
   output logic [ADDR_WIDTH-1:0]                 s_araddr,
   output logic                                  s_arvalid,
   input  logic                                  s_arready,
   input  logic [DATA_WIDTH-1:0]                 s_rdata,
   input  logic [1:0]                            s_rresp,
   input  logic                                  s_rvalid,
   output logic                                  s_rready,
   output logic [ADDR_WIDTH-1:0]                 s_awaddr,
   output logic                                  s_awvalid,
   input  logic                                  s_awready,
   output logic [DATA_WIDTH-1:0]                 s_wdata,
   output logic [DATA_WIDTH/8-1:0]               s_wstrb,
   output logic                                  s_wvalid,
   input  logic                                  s_wready,
   input  logic [1:0]                            s_bresp,
   input  logic                                  s_bvalid,
   output logic                                  s_bready
);

   localparam int SW = DATA_WIDTH / 8;
   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, RDATA, WRESP} state_t;

   state_t                 state, state_nx;
   logic [NUM_MASTERS-1:0] winner;
   logic [IW-1:0]          widx, gidx;
   logic                   gact, aw_en, ar_hs, aw_hs;

`ifdef ARB_ROUND_ROBIN_EN
   logic [IW-1:0] last;
   logic [IW-1:0] cand;
   logic          found;

   // Search starts just after the last winner, so it has lowest priority.
   always_comb begin
      widx  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = IW'((int'(last) + k) % NUM_MASTERS);
         if (!found && req[cand]) begin
            found = 1'b1;
            widx  = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last <= IW'(NUM_MASTERS - 1);
      else if (state == IDLE && |req)
         last <= widx;
   end
`else
   always_comb begin
      widx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (req[i]) widx = IW'(i);
   end
`endif

   assign winner = (|req) ? (NUM_MASTERS'(1) << widx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE)
            grant <= winner;
         else if (state_nx == IDLE)
            grant <= '0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (|req) state_nx = GRANT;
         GRANT:   if (ar_hs) state_nx = RDATA;
                  else if (aw_hs) state_nx = WRESP;
         RDATA:   if (s_rvalid && s_rready) state_nx = IDLE;
         WRESP:   if (s_bvalid && s_bready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant[i]) gidx = IW'(i);
   end

   assign gact  = |grant;
   // A pending read from the granted master holds off its AW.
   assign aw_en = gact && (state == GRANT) && !m_arvalid[gidx];
   assign ar_hs = s_arvalid && s_arready;
   assign aw_hs = s_awvalid && s_awready;

   always_comb begin
      s_araddr  = '0;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      s_awaddr  = '0;
      s_awvalid = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      if (gact) begin
         s_araddr = m_araddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
         s_awaddr = m_awaddr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
         s_wdata  = m_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
         s_wstrb  = m_wstrb[gidx*SW +: SW];
         if (state == GRANT) begin
            s_arvalid       = m_arvalid[gidx];
            m_arready[gidx] = s_arready;
            s_awvalid       = aw_en && m_awvalid[gidx];
            m_awready[gidx] = aw_en && s_awready;
         end
         if (state == GRANT || state == WRESP) begin
            s_wvalid       = m_wvalid[gidx];
            m_wready[gidx] = s_wready;
         end
         if (state == RDATA) begin
            s_rready       = m_rready[gidx];
            m_rvalid[gidx] = s_rvalid;
         end
         if (state == WRESP) begin
            s_bready       = m_bready[gidx];
            m_bvalid[gidx] = s_bvalid;
         end
      end
   end

   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_bresp = s_bresp;

   a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   a_grant_stable:  assert property (@(posedge clk) disable iff (rst)
                       (state != IDLE && state_nx != IDLE) |=> $stable(grant));

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// Bench for ysyx_23060184_mem_arbiter: vector table plus multi-cycle sequences,
// with a responding slave model and a response scoreboard.
module tb_ysyx_23060184_mem_arbiter;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic              clk, rst;
   logic [NM-1:0]     req, grant;
   logic [NM*AW-1:0]  m_araddr, m_awaddr;
   logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
   logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic [DW-1:0]     m_rdata;
   logic [1:0]        m_rresp, m_bresp;
   logic [NM*DW-1:0]  m_wdata;
   logic [NM*SW-1:0]  m_wstrb;
   logic [AW-1:0]     s_araddr, s_awaddr;
   logic              s_arvalid, s_arready, s_rvalid, s_rready;
   logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic [DW-1:0]     s_rdata, s_wdata;
   logic [1:0]        s_rresp, s_bresp;
   logic [SW-1:0]     s_wstrb;

   ysyx_23060184_mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: answers R after sl_rdelay idle cycles, B once both AW and W landed.
   // It ignores rst so a response can arrive after the arbiter was reset.
   logic [DW-1:0] sl_rdata, last_wdata;
   logic [AW-1:0] last_araddr, last_awaddr;
   logic [SW-1:0] last_wstrb;
   logic [1:0]    sl_rresp, sl_bresp;
   logic          sl_flush, rpend, awgot, wgot;
   int            sl_rdelay, rwait;

   always @(posedge clk) begin
      if (sl_flush) begin
         s_rvalid <= 1'b0;
         s_bvalid <= 1'b0;
         rpend    <= 1'b0;
         awgot    <= 1'b0;
         wgot     <= 1'b0;
         rwait    <= 0;
      end else begin
         if (s_arvalid && s_arready) begin
            rpend       <= 1'b1;
            rwait       <= sl_rdelay;
            last_araddr <= s_araddr;
         end else if (rpend) begin
            if (rwait == 0) begin
               s_rvalid <= 1'b1;
               s_rdata  <= sl_rdata;
               s_rresp  <= sl_rresp;
               rpend    <= 1'b0;
            end else begin
               rwait <= rwait - 1;
            end
         end
         if (s_rvalid && s_rready) s_rvalid <= 1'b0;
         if (s_awvalid && s_awready) begin
            awgot       <= 1'b1;
            last_awaddr <= s_awaddr;
         end
         if (s_wvalid && s_wready) begin
            wgot       <= 1'b1;
            last_wdata <= s_wdata;
            last_wstrb <= s_wstrb;
         end
         if ((awgot || (s_awvalid && s_awready)) && (wgot || (s_wvalid && s_wready))) begin
            s_bvalid <= 1'b1;
            s_bresp  <= sl_bresp;
            awgot    <= 1'b0;
            wgot     <= 1'b0;
         end
         if (s_bvalid && s_bready) s_bvalid <= 1'b0;
      end
   end

   typedef struct {
      int          m;
      bit          wr;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   typedef struct {
      int          m;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      int          dly;
      logic [1:0]  exp_grant;
   } vec_t;

   exp_t sb[$];
   vec_t vt[6];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_read(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int rdly, input bit drop);
      exp_t          e;
      bit            ar_done, r_done;
      logic [NM-1:0] own;
      own       = NM'(1) << m;
      ar_done   = 1'b0;
      r_done    = 1'b0;
      sl_rdata  = data;
      sl_rresp  = resp;
      sl_rdelay = rdly;
      m_araddr[m*AW +: AW] = addr;
      m_arvalid = m_arvalid | own;
      m_rready  = m_rready | own;
      sb.push_back('{m: m, wr: 1'b0, data: data, resp: resp});
      #1;
      for (int n = 0; n < 40 && !r_done; n++) begin
         chk("rd_grant", 32'(grant), 32'(own));
         chk("rd_isolation", 32'((m_arready & ~own) | (m_rvalid & ~own)), 0);
         if ((m_arvalid & m_arready & own) != 0) begin
            chk("rd_araddr", s_araddr, addr);
            ar_done = 1'b1;
         end
         if ((m_rvalid & own) != 0) begin
            e = sb.pop_front();
            chk("rd_data", m_rdata, e.data);
            chk("rd_resp", 32'(m_rresp), 32'(e.resp));
            chk("rd_master", 32'(m_rvalid), 32'(NM'(1) << e.m));
            r_done = 1'b1;
         end
         @(negedge clk);
         if (ar_done) m_arvalid = m_arvalid & ~own;
         if (r_done) begin
            m_rready = m_rready & ~own;
            if (drop) req = req & ~own;
         end
         #1;
      end
      if (!r_done) chk("rd_timeout", 0, 1);
      else begin
         chk("rd_release", 32'(grant), 0);
         chk("rd_slave_addr", last_araddr, addr);
      end
   endtask

   task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int awdly,
                           input bit drop);
      exp_t          e;
      bit            aw_done, w_done, b_done;
      logic [NM-1:0] own;
      own      = NM'(1) << m;
      aw_done  = 1'b0;
      w_done   = 1'b0;
      b_done   = 1'b0;
      sl_bresp = resp;
      m_awaddr[m*AW +: AW] = addr;
      m_wdata[m*DW +: DW]  = data;
      m_wstrb[m*SW +: SW]  = strb;
      m_wvalid = m_wvalid | own;
      m_bready = m_bready | own;
      if (awdly == 0) m_awvalid = m_awvalid | own;
      sb.push_back('{m: m, wr: 1'b1, data: data, resp: resp});
      #1;
      for (int n = 0; n < 40 && !b_done; n++) begin
         chk("wr_grant", 32'(grant), 32'(own));
         chk("wr_isolation", 32'((m_awready | m_wready | m_bvalid) & ~own), 0);
         if ((m_awvalid & m_awready & own) != 0) begin
            chk("wr_awaddr", s_awaddr, addr);
            aw_done = 1'b1;
         end
         if ((m_wvalid & m_wready & own) != 0) begin
            chk("wr_wdata", s_wdata, data);
            chk("wr_wstrb", 32'(s_wstrb), 32'(strb));
            w_done = 1'b1;
         end
         if ((m_bvalid & own) != 0) begin
            e = sb.pop_front();
            chk("wr_bresp", 32'(m_bresp), 32'(e.resp));
            chk("wr_slave_data", last_wdata, e.data);
            chk("wr_slave_addr", last_awaddr, addr);
            chk("wr_master", 32'(m_bvalid), 32'(NM'(1) << e.m));
            b_done = 1'b1;
         end
         @(negedge clk);
         if (aw_done) m_awvalid = m_awvalid & ~own;
         else if (n + 1 >= awdly) m_awvalid = m_awvalid | own;
         if (w_done) m_wvalid = m_wvalid & ~own;
         if (b_done) begin
            m_bready = m_bready & ~own;
            if (drop) req = req & ~own;
         end
         #1;
      end
      if (!b_done) chk("wr_timeout", 0, 1);
      else chk("wr_release", 32'(grant), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] exp_g;
      bit         got;

      vt[0] = '{0, 1'b0, 32'h8000_0000, 32'h0000_0413, 4'h0, 2'b00, 0, 2'b01};
      vt[1] = '{1, 1'b0, 32'h8000_2000, 32'h1234_5678, 4'h0, 2'b10, 1, 2'b10};
      vt[2] = '{1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 2'b10};
      vt[3] = '{0, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'h3, 2'b11, 2, 2'b01};
      vt[4] = '{0, 1'b0, 32'h8000_0008, 32'hA5A5_5A5A, 4'h0, 2'b11, 3, 2'b01};
      vt[5] = '{1, 1'b1, 32'h8000_0010, 32'h0BAD_F00D, 4'h1, 2'b01, 1, 2'b10};

      rst = 1'b1;  req = '0;  sl_flush = 1'b1;
      sl_rdata = '0;  sl_rresp = '0;  sl_bresp = '0;  sl_rdelay = 0;
      s_arready = 1'b1;  s_awready = 1'b1;  s_wready = 1'b1;
      m_araddr = '0;  m_awaddr = '0;  m_wdata = '0;  m_wstrb = '0;
      // Valids high during reset must not leak through while nothing is granted.
      m_arvalid = '1;  m_awvalid = '1;  m_wvalid = '1;  m_rready = '1;  m_bready = '1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_s_valids", 32'({s_arvalid, s_awvalid, s_wvalid}), 0);
      chk("rst_s_readies", 32'({s_rready, s_bready}), 0);
      chk("rst_m_outputs", 32'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 0);
      @(negedge clk);
      rst = 1'b0;  sl_flush = 1'b0;
      m_arvalid = '0;  m_awvalid = '0;  m_wvalid = '0;  m_rready = '0;  m_bready = '0;

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req = req | (NM'(1) << vt[i].m);
         #1;
         chk("vec_grant_latency", 32'(grant), 0);
         @(negedge clk);
         #1;
         chk("vec_grant", 32'(grant), 32'(vt[i].exp_grant));
         if (vt[i].wr)
            do_write(vt[i].m, vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp, vt[i].dly, 1'b1);
         else
            do_read(vt[i].m, vt[i].addr, vt[i].data, vt[i].resp, vt[i].dly, 1'b1);
      end

      // Simultaneous requests: LSU write first, IFU read after one idle cycle.
      @(negedge clk);
      req = 2'b11;
      @(negedge clk);
      #1;
      chk("t2_first_grant", 32'(grant), 32'(2'b10));
      do_write(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 1'b1);
      @(negedge clk);
      #1;
      chk("t2_second_grant", 32'(grant), 32'(2'b01));
      do_read(0, 32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1'b1);

      // Slow LSU read while IFU requests with arvalid already up.
      @(negedge clk);
      req = 2'b10;
      @(negedge clk);
      #1;
      chk("t5_lsu_grant", 32'(grant), 32'(2'b10));
      req = 2'b11;
      m_araddr[0 +: AW] = 32'h8000_0040;
      m_arvalid = m_arvalid | 2'b01;
      do_read(1, 32'h8000_3000, 32'h5555_AAAA, 2'b00, 5, 1'b1);
      @(negedge clk);
      #1;
      chk("t5_ifu_grant", 32'(grant), 32'(2'b01));
      do_read(0, 32'h8000_0040, 32'h1111_2222, 2'b00, 0, 1'b1);

      // Continuous requests from both masters after a fresh reset.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         got = 1'b0;
         for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            #1;
            if (grant != '0) got = 1'b1;
         end
`ifdef ARB_ROUND_ROBIN_EN
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b10;
`endif
         chk("t3_grant_order", 32'(grant), 32'(exp_g));
         do_read((exp_g == 2'b01) ? 0 : 1, 32'h8000_4000 + 32'(t * 4),
                 32'h7000_0000 + 32'(t), 2'b00, 0, 1'b0);
      end
      req = '0;

      // Reset while a read is in flight; the late response must be dropped.
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      #1;
      chk("t6_grant", 32'(grant), 32'(2'b01));
      sl_rdata  = 32'hBAD0_0BAD;
      sl_rresp  = 2'b00;
      sl_rdelay = 4;
      m_araddr[0 +: AW] = 32'h8000_0100;
      m_arvalid = 2'b01;
      m_rready  = 2'b01;
      @(negedge clk);
      m_arvalid = '0;
      req = '0;
      #1;
      chk("t6_held_in_rdata", 32'(grant), 32'(2'b01));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_s_valids", 32'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 0);
      for (int n = 0; n < 8; n++) begin
         chk("t6_no_late_rvalid", 32'({m_rvalid, s_rready}), 0);
         @(negedge clk);
         #1;
      end
      chk("t6_slave_responded", 32'(s_rvalid), 1);
      sl_flush = 1'b1;
      m_rready = '0;
      @(negedge clk);
      sl_flush = 1'b0;

      chk("sb_empty", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
